// File: rtl/comb_pkg.sv
// Shared types for the comb_engine combination calculator: controller states
// and the stack sizing rule used for the elaboration-time DEPTH check.
package comb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Symmetry reduction bounds occupancy by n+1, so 2**NW entries always suffice.
  localparam int unsigned DEPTH_RADIX = 2;

  function automatic bit depth_ok(input int unsigned depth, input int unsigned nw);
    return depth >= (DEPTH_RADIX ** nw);
  endfunction

endpackage

// File: rtl/comb_stack.sv
// LIFO of (n, m) recursion nodes: load one entry, pop, or replace the top and
// push a second entry in the same cycle. Only the stack pointer is reset.
module comb_stack
  import comb_pkg::*;
#(
  parameter int NW    = 4,
  parameter int DEPTH = 16,
  localparam int EW   = 2 * NW,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [EW-1:0] load_entry,
  input  logic          pop,
  input  logic          split,
  input  logic [EW-1:0] split_lo,
  input  logic [EW-1:0] split_hi,
  output logic [EW-1:0] top,
  output logic [CW-1:0] count,
  output logic          empty
);

  logic [EW-1:0] mem_r [DEPTH];
  logic [CW-1:0] sp_r;
  logic [AW-1:0] top_idx_s;
  logic [AW-1:0] push_idx_s;

  // Address of the current top and of the slot just above it.
  always_comb begin
    push_idx_s = sp_r[AW-1:0];
    top_idx_s  = sp_r[AW-1:0] - AW'(1);
  end

  // Entry storage; a split rewrites the top in place and stacks its sibling.
  always_ff @(posedge clk) begin
    if (load) begin
      mem_r[0] <= load_entry;
    end else if (split) begin
      mem_r[top_idx_s]  <= split_lo;
      mem_r[push_idx_s] <= split_hi;
    end
  end

  // Stack pointer: load sets one entry, split nets +1, pop -1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_r <= {CW{1'b0}};
    end else if (load) begin
      sp_r <= CW'(1);
    end else if (split) begin
      sp_r <= sp_r + CW'(1);
    end else if (pop) begin
      sp_r <= sp_r - CW'(1);
    end
  end

  assign top   = mem_r[top_idx_s];
  assign count = sp_r;
  assign empty = (sp_r == {CW{1'b0}});

endmodule

// File: rtl/comb_engine.sv
// C(n,m) coprocessor: depth-first binomial recursion over comb_stack, one node per cycle.
// Define COMB_SAT_EN to clamp the accumulator at all-ones on overflow instead of wrapping.
module comb_engine
  import comb_pkg::*;
#(
  parameter int NW    = 4,
  parameter int OW    = 13,
  parameter int DEPTH = 2 ** NW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] n,
  input  logic [NW-1:0] m,
  output logic          busy,
  output logic          done,
  output logic [OW-1:0] out_,
  output logic          err,
  output logic          ovf
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [NW-1:0] n;
    logic [NW-1:0] m;
  } entry_t;

  if (!depth_ok(DEPTH, NW)) begin : g_depth_check
    $error("comb_engine: DEPTH must be at least 2**NW");
  end

  state_t        state_r;
  logic [OW-1:0] acc_r;
  logic          err_r;
  logic          ovf_r;
  logic          busy_r;
  logic          done_r;

  entry_t        top_s;
  entry_t        load_entry_s;
  entry_t        split_lo_s;
  entry_t        split_hi_s;
  logic [CW-1:0] count_s;
  logic          empty_s;
  logic [NW-1:0] n_minus_m_s;
  logic [NW-1:0] m_red_s;
  logic          bad_arg_s;
  logic          base_s;
  logic          last_s;
  logic          load_s;
  logic          pop_s;
  logic          split_s;
  logic [OW:0]   acc_sum_s;

  // Argument reduction, node classification and stack control for this cycle.
  always_comb begin
    n_minus_m_s  = n - m;
    bad_arg_s    = (m > n);
    m_red_s      = (n_minus_m_s < m) ? n_minus_m_s : m;
    load_entry_s = {n, m_red_s};
    base_s       = (top_s.m == {NW{1'b0}}) || (top_s.m == top_s.n);
    last_s       = base_s && (count_s == CW'(1));
    load_s       = (state_r == IDLE) && start && !bad_arg_s;
    pop_s        = (state_r == RUN) && !empty_s && base_s;
    split_s      = (state_r == RUN) && !empty_s && !base_s;
    split_lo_s   = {top_s.n - NW'(1), top_s.m};
    split_hi_s   = {top_s.n - NW'(1), top_s.m - NW'(1)};
    acc_sum_s    = {1'b0, acc_r} + (OW + 1)'(1);
  end

  comb_stack #(
    .NW    (NW),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk        (clk),
    .rst        (rst),
    .load       (load_s),
    .load_entry (load_entry_s),
    .pop        (pop_s),
    .split      (split_s),
    .split_lo   (split_lo_s),
    .split_hi   (split_hi_s),
    .top        (top_s),
    .count      (count_s),
    .empty      (empty_s)
  );

  // Controller, accumulator and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      acc_r   <= {OW{1'b0}};
      err_r   <= 1'b0;
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            acc_r  <= {OW{1'b0}};
            err_r  <= bad_arg_s;
            ovf_r  <= 1'b0;
            busy_r <= 1'b1;
            if (bad_arg_s) begin
              state_r <= FIN;
              done_r  <= 1'b1;
            end else begin
              state_r <= RUN;
              done_r  <= 1'b0;
            end
          end
        end
        RUN: begin
          if (pop_s) begin
`ifdef COMB_SAT_EN
            if (acc_sum_s[OW]) begin
              acc_r <= {OW{1'b1}};
            end else begin
              acc_r <= acc_sum_s[OW-1:0];
            end
`else
            acc_r <= acc_sum_s[OW-1:0];
`endif
            ovf_r <= ovf_r | acc_sum_s[OW];
            if (last_s) begin
              state_r <= FIN;
              done_r  <= 1'b1;
            end
          end
        end
        FIN: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign out_ = acc_r;
  assign err  = err_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_comb_engine.sv
// Scoreboard bench for comb_engine: a 13-bit default instance and an 8-bit overflow instance.
module tb_comb_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [3:0]  n = 4'd0;
  logic [3:0]  m = 4'd0;
  logic        busy_a, done_a, err_a, ovf_a;
  logic [12:0] out_a;
  logic        busy_b, done_b, err_b, ovf_b;
  logic [7:0]  out_b;

  typedef struct packed {
    logic [31:0] out;
    logic        err;
    logic        ovf;
    logic [31:0] lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pascal [16][16];

  always #5 clk = ~clk;

  comb_engine #(.NW(4), .OW(13)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .n(n), .m(m),
    .busy(busy_a), .done(done_a), .out_(out_a), .err(err_a), .ovf(ovf_a)
  );

  comb_engine #(.NW(4), .OW(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .n(n), .m(m),
    .busy(busy_b), .done(done_b), .out_(out_b), .err(err_b), .ovf(ovf_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  // Latency counts cycles from the start edge to the cycle in which done is seen.
  function automatic exp_t model(input bit sel, input int nn, input int mm);
    exp_t e;
    int lim;
    int c;
    lim = sel ? 256 : 8192;
    if (mm > nn) begin
      e.out = 32'd0; e.err = 1'b1; e.ovf = 1'b0; e.lat = 32'd1;
    end else begin
      c     = pascal[nn][mm];
      e.err = 1'b0;
      e.lat = 32'(2 * c);
      e.ovf = (c >= lim);
`ifdef COMB_SAT_EN
      e.out = 32'((c >= lim) ? lim - 1 : c);
`else
      e.out = 32'(c % lim);
`endif
    end
    return e;
  endfunction

  task automatic run(input bit sel, input int nn, input int mm, input bit poke, input string tag);
    exp_t e;
    int   lat;
    n = nn[3:0];
    m = mm[3:0];
    set_start(sel, 1'b1);
    sb.push_back(model(sel, nn, mm));
    @(posedge clk); #1;
    set_start(sel, 1'b0);
    check({tag, "_busy"}, 32'(sel ? busy_b : busy_a), 32'd1);
    lat = 1;
    while (!(sel ? done_b : done_a) && lat < 20000) begin
      if (poke && lat == 3) begin
        n = 4'd15; m = 4'd1;
        set_start(sel, 1'b1);
      end else begin
        set_start(sel, 1'b0);
      end
      @(posedge clk); #1;
      lat++;
    end
    set_start(sel, 1'b0);
    e = sb.pop_front();
    check({tag, "_lat"}, 32'(lat), e.lat);
    check({tag, "_out"}, sel ? 32'(out_b) : 32'(out_a), e.out);
    check({tag, "_err"}, 32'(sel ? err_b : err_a), 32'(e.err));
    check({tag, "_ovf"}, 32'(sel ? ovf_b : ovf_a), 32'(e.ovf));
    // A start during the done cycle must be ignored.
    n = 4'd1; m = 4'd0;
    set_start(sel, 1'b1);
    @(posedge clk); #1;
    set_start(sel, 1'b0);
    check({tag, "_idle_busy"}, 32'(sel ? busy_b : busy_a), 32'd0);
    check({tag, "_idle_done"}, 32'(sel ? done_b : done_a), 32'd0);
    check({tag, "_hold"}, sel ? 32'(out_b) : 32'(out_a), e.out);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        if (j == 0 || j == i) pascal[i][j] = 1;
        else if (j > i)       pascal[i][j] = 0;
        else                  pascal[i][j] = pascal[i-1][j-1] + pascal[i-1][j];
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_out", 32'(out_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_err", 32'(err_a), 32'd0);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    check("rst_out_b", 32'(out_b), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    run(1'b0, 4, 2, 1'b1, "c4_2");
    run(1'b0, 15, 7, 1'b1, "c15_7");
    run(1'b0, 5, 5, 1'b0, "c5_5");
    run(1'b0, 5, 0, 1'b0, "c5_0");
    run(1'b0, 9, 7, 1'b1, "c9_7");
    run(1'b0, 3, 5, 1'b0, "err3_5");
    run(1'b0, 6, 3, 1'b1, "c6_3");
    run(1'b0, 15, 15, 1'b0, "c15_15");
    run(1'b1, 12, 6, 1'b1, "ovf12_6");
    run(1'b1, 4, 2, 1'b1, "b4_2");

    // Abort a long run with reset, then confirm a fresh request is clean.
    n = 4'd15; m = 4'd7; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("abort_busy", 32'(busy_a), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_out", 32'(out_a), 32'd0);
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    check("mid_rst_done", 32'(done_a), 32'd0);
    check("mid_rst_err", 32'(err_a), 32'd0);
    check("mid_rst_ovf", 32'(ovf_a), 32'd0);
    @(posedge clk); #1;
    check("mid_rst_hold", 32'(busy_a), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    run(1'b0, 4, 1, 1'b1, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
